// File: rtl/access_anomaly_monitor.sv
// access_anomaly_monitor: stamps each access event with a free-running timestamp,
// tags it with burst-rate and novel-pairing features, and queues the tagged record
// in a small FIFO drained by a valid/ready consumer.
module access_anomaly_monitor #(
    parameter int USER_W     = 4,
    parameter int RES_W      = 4,
    parameter int TS_W       = 16,
    parameter int WINDOW     = 16,
    parameter int BURST_TH   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt_valid,
    input  logic [USER_W-1:0] user_id,
    input  logic [RES_W-1:0]  resource_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W-1:0]   out_ts,
    output logic [USER_W-1:0] out_user,
    output logic [RES_W-1:0]  out_res,
    output logic [1:0]        out_flag,
    output logic              alert,
    output logic [7:0]        overflow_cnt
);

    localparam int NUSERS = 1 << USER_W;
    localparam int NRES   = 1 << RES_W;
    localparam int EP_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REC_W  = TS_W + USER_W + RES_W + 2;

    localparam logic [EP_W-1:0]  EP_LAST   = EP_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   BURST_LIM = (CNT_W + 1)'(BURST_TH);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [TS_W-1:0]   tsCount_q, tsCount_d;
    logic [EP_W-1:0]   epoch_q, epoch_d;
    logic [CNT_W-1:0]  userCnt_q [NUSERS];
    logic [NRES-1:0]   seenMap_q [NUSERS];
    logic [REC_W-1:0]  fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W:0]    fifoCount_q, fifoCount_d;
    logic              alert_q, alert_d;
    logic [7:0]        overflow_q, overflow_d;

    logic              epochLast;
    logic [CNT_W:0]    cntPlusOne;
    logic [1:0]        evtFlags;
    logic              fifoFull;
    logic              popFire;
    logic              pushFire;
    logic              dropFire;
    logic [REC_W-1:0]  headRec;

    // Feature extraction for the incoming event, judged against pre-update state
    always_comb begin
        epochLast   = (epoch_q == EP_LAST);
        cntPlusOne  = {1'b0, userCnt_q[user_id]} + {{CNT_W{1'b0}}, 1'b1};
        evtFlags[0] = (cntPlusOne > BURST_LIM);
        evtFlags[1] = ~seenMap_q[user_id][resource_id];
        fifoFull    = (fifoCount_q == FIFO_FULL);
        popFire     = out_valid && out_ready;
        pushFire    = evt_valid && (!fifoFull || popFire);
        dropFire    = evt_valid && fifoFull && !popFire;
    end

    // Next-state for timestamp, epoch, FIFO bookkeeping, alert and overflow count
    always_comb begin
        tsCount_d   = tsCount_q + 1'b1;
        epoch_d     = epochLast ? '0 : epoch_q + 1'b1;
        wrPtr_d     = pushFire ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d     = popFire ? rdPtr_q + 1'b1 : rdPtr_q;
        fifoCount_d = fifoCount_q;
        if (pushFire && !popFire) begin
            fifoCount_d = fifoCount_q + 1'b1;
        end else if (popFire && !pushFire) begin
            fifoCount_d = fifoCount_q - 1'b1;
        end
        alert_d    = pushFire && (evtFlags != 2'b00);
        overflow_d = (dropFire && overflow_q != 8'hFF) ? overflow_q + 1'b1 : overflow_q;
    end

    // Scalar state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tsCount_q   <= '0;
            epoch_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            alert_q     <= 1'b0;
            overflow_q  <= '0;
        end else begin
            tsCount_q   <= tsCount_d;
            epoch_q     <= epoch_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
            alert_q     <= alert_d;
            overflow_q  <= overflow_d;
        end
    end

    // Per-user saturating counters; the epoch-end clear takes priority over an increment
    always_ff @(posedge clk) begin
        if (rst || epochLast) begin
            for (int u = 0; u < NUSERS; u++) begin
                userCnt_q[u] <= '0;
            end
        end else if (evt_valid && userCnt_q[user_id] != CNT_MAX) begin
            userCnt_q[user_id] <= userCnt_q[user_id] + 1'b1;
        end
    end

    // Pairing bitmaps remember every user/resource combination seen since reset, dropped or not
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int u = 0; u < NUSERS; u++) begin
                seenMap_q[u] <= '0;
            end
        end else if (evt_valid) begin
            seenMap_q[user_id][resource_id] <= 1'b1;
        end
    end

    // Record storage; contents are don't-care until written, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (!rst && pushFire) begin
            fifoMem_q[wrPtr_q] <= {tsCount_q, user_id, resource_id, evtFlags};
        end
    end

    // Head record presented to the consumer, forced to zero while the FIFO is empty
    always_comb begin
        headRec      = fifoMem_q[rdPtr_q];
        out_valid    = (fifoCount_q != '0);
        out_ts       = '0;
        out_user     = '0;
        out_res      = '0;
        out_flag     = '0;
        if (out_valid) begin
            out_ts   = headRec[REC_W-1 -: TS_W];
            out_user = headRec[RES_W+2 +: USER_W];
            out_res  = headRec[2 +: RES_W];
            out_flag = headRec[1:0];
        end
        alert        = alert_q;
        overflow_cnt = overflow_q;
    end

endmodule

// File: tb/tb_access_anomaly_monitor.sv
// tb_access_anomaly_monitor: directed vectors with hand-computed expectations.
module tb_access_anomaly_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt_valid = 1'b0;
    logic [3:0] user_id = '0;
    logic [3:0] resource_id = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [15:0] out_ts;
    logic [3:0] out_user;
    logic [3:0] out_res;
    logic [1:0] out_flag;
    logic       alert;
    logic [7:0] overflow_cnt;

    int assertCount = 0;
    int failCount   = 0;

    access_anomaly_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .evt_valid    (evt_valid),
        .user_id      (user_id),
        .resource_id  (resource_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ts       (out_ts),
        .out_user     (out_user),
        .out_res      (out_res),
        .out_flag     (out_flag),
        .alert        (alert),
        .overflow_cnt (overflow_cnt)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Safety net so the run cannot hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] usr, input logic [3:0] res);
        evt_valid   = valid;
        user_id     = usr;
        resource_id = res;
        tick();
    endtask

    // After this returns, the current cycle is ts 0 with reset released
    task automatic doReset();
        rst       = 1'b1;
        evt_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] firstTs;
        logic [15:0] lastTs;
        logic [1:0] expFlag2 [4];
        logic       expAlert2 [4];
        logic [1:0] expFlag3 [5];

        expFlag2  = '{2'b10, 2'b00, 2'b00, 2'b01};
        expAlert2 = '{1'b1, 1'b0, 1'b0, 1'b1};
        expFlag3  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};

        // Reset state and single-event latency
        #1;
        doReset();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_ts", 32'(out_ts), 32'd0);
        checkOutput("rst_alert", 32'(alert), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_cnt), 32'd0);
        applyStimulus(1'b1, 4'd2, 4'd5);
        checkOutput("s1_out_valid", 32'(out_valid), 32'd1);
        checkOutput("s1_out_ts", 32'(out_ts), 32'd0);
        checkOutput("s1_out_user", 32'(out_user), 32'd2);
        checkOutput("s1_out_res", 32'(out_res), 32'd5);
        checkOutput("s1_out_flag", 32'(out_flag), 32'd2);
        checkOutput("s1_alert", 32'(alert), 32'd1);
        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("s1_alert_pulse", 32'(alert), 32'd0);
        checkOutput("s1_head_hold", 32'(out_ts), 32'd0);

        // Burst within one epoch for a single user
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd2, 4'd5);
            checkOutput($sformatf("s2_ts_%0d", i), 32'(out_ts), 32'(i));
            checkOutput($sformatf("s2_flag_%0d", i), 32'(out_flag), 32'(expFlag2[i]));
            checkOutput($sformatf("s2_alert_%0d", i), 32'(alert), 32'(expAlert2[i]));
        end
        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("s2_drained", 32'(out_valid), 32'd0);

        // Epoch boundary clears the counter
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 4'd0, 4'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd3, 4'd1);
            checkOutput($sformatf("s3_ts_%0d", 12 + i), 32'(out_ts), 32'(12 + i));
            checkOutput($sformatf("s3_flag_%0d", 12 + i), 32'(out_flag), 32'(expFlag3[i]));
        end

        // Overflow with consumer stalled, then strict-order drain
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i), 4'd0);
            checkOutput($sformatf("s4_head_ts_%0d", i), 32'(out_ts), 32'd0);
        end
        checkOutput("s4_overflow", 32'(overflow_cnt), 32'd2);
        checkOutput("s4_head_flag", 32'(out_flag), 32'd2);
        evt_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("s4_drain_valid_%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("s4_drain_ts_%0d", i), 32'(out_ts), 32'(i));
            checkOutput($sformatf("s4_drain_user_%0d", i), 32'(out_user), 32'(i));
            tick();
        end
        checkOutput("s4_empty", 32'(out_valid), 32'd0);

        // Mid-stream reset discards queued records and clears overflow
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'd7, 4'd1);
        applyStimulus(1'b1, 4'd8, 4'd2);
        applyStimulus(1'b1, 4'd9, 4'd3);
        checkOutput("s6_queued_valid", 32'(out_valid), 32'd1);
        checkOutput("s6_overflow_before", 32'(overflow_cnt), 32'd2);
        rst       = 1'b1;
        evt_valid = 1'b1;
        user_id   = 4'd2;
        resource_id = 4'd5;
        tick();
        checkOutput("s6_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("s6_rst_overflow", 32'(overflow_cnt), 32'd0);
        tick();
        checkOutput("s6_rst_evt_ignored", 32'(out_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 4'd2, 4'd5);
        checkOutput("s6_novel_again", 32'(out_flag), 32'd2);
        checkOutput("s6_ts_zero", 32'(out_ts), 32'd0);

        // Full FIFO with simultaneous push and pop
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i), 4'd3);
        end
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'd9, 4'd3);
        checkOutput("s5_overflow", 32'(overflow_cnt), 32'd0);
        evt_valid = 1'b0;
        n = 0;
        firstTs = out_ts;
        lastTs = '0;
        while (out_valid && n < 20) begin
            lastTs = out_ts;
            n++;
            tick();
        end
        checkOutput("s5_first_ts", 32'(firstTs), 32'd1);
        checkOutput("s5_occupancy", 32'(n), 32'd8);
        checkOutput("s5_last_ts", 32'(lastTs), 32'd8);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
